exe_stage_pipe: RTL and testbench

Parametrised, registered execute stage for the pipelined CPU. It sits between ID/EX and EX/MEM and selects ALU operands from register data, a shift amount or an immediate. It computes single-cycle ALU results and registers them with the control bits into the EX/MEM outputs. It adds an iterative unsigned multiply/divide unit (MDU) with HI/LO registers and a pipeline-stall handshake.

---
 rtl/exe_stage_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_exe_stage_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered execute stage (ALU + EX/MEM pipeline register).
// Optional iterative unsigned multiply/divide unit with HI/LO and a stall
// handshake is built when the macro EXE_MDU_EN is defined.
module exe_stage_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SH_W  = $clog2(WIDTH),
  parameter int unsigned RN_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic             eshift,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic             em2reg,
  input  logic             ewmem,
  input  logic             ewreg,
  input  logic [RN_W-1:0]  ern,
  output logic             stall,
  output logic             busy,
  output logic             m_valid,
  output logic             mm2reg,
  output logic             mwmem,
  output logic             mwreg,
  output logic [RN_W-1:0]  mrn,
  output logic [WIDTH-1:0] malu,
  output logic [WIDTH-1:0] mb,
  output logic             mz
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;
  logic             w_nop;
  logic             w_no_wb;

`ifdef EXE_MDU_EN
  localparam logic [3:0]  OP_MULTU = 4'd8;
  localparam logic [3:0]  OP_DIVU  = 4'd9;
  localparam logic [3:0]  OP_MFHI  = 4'd10;
  localparam logic [3:0]  OP_MFLO  = 4'd11;
  localparam logic        ST_IDLE  = 1'b0;
  localparam logic        ST_BUSY  = 1'b1;
  localparam int unsigned CNT_W    = SH_W + 1;

  logic             r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_div, w_div_nxt;
  logic [WIDTH-1:0] r_opb, w_opb_nxt;
  logic [WIDTH-1:0] r_acc_hi, w_acc_hi_nxt;
  logic [WIDTH-1:0] r_acc_lo, w_acc_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;
  logic             w_mdu_op;
  logic             w_issue;

  assign w_mdu_op = in_valid & (ealuc[3:2] == 2'b10);
  assign busy     = (r_state == ST_BUSY);
  assign stall    = busy & w_mdu_op;
  assign w_nop    = (ealuc[3:2] == 2'b11);
  assign w_no_wb  = (ealuc == OP_MULTU) | (ealuc == OP_DIVU);
  assign w_issue  = w_accept & w_no_wb;

  // One iteration: shift-add for multiply, restoring subtract for divide.
  // A zero divisor never fails the subtract, so LO ends all ones and HI
  // ends holding the dividend without any special casing.
  always_comb begin
    w_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    w_shl  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_diff = w_shl - {1'b0, r_opb};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_step_hi = w_diff[WIDTH-1:0];
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_step_hi = w_shl[WIDTH-1:0];
        w_step_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // MDU next state: issue loads operands, BUSY iterates until the counter hits 1.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_opb_nxt    = r_opb;
    w_acc_hi_nxt = r_acc_hi;
    w_acc_lo_nxt = r_acc_lo;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_nxt  = ST_BUSY;
          w_cnt_nxt    = CNT_W'(WIDTH);
          w_div_nxt    = (ealuc == OP_DIVU);
          w_opb_nxt    = eb;
          w_acc_hi_nxt = '0;
          w_acc_lo_nxt = ea;
        end
      end
      default: begin
        w_acc_hi_nxt = w_step_hi;
        w_acc_lo_nxt = w_step_lo;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_hi_nxt    = w_step_hi;
          w_lo_nxt    = w_step_lo;
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // MDU state register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_opb    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_opb    <= w_opb_nxt;
      r_acc_hi <= w_acc_hi_nxt;
      r_acc_lo <= w_acc_lo_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end
`else
  assign stall   = 1'b0;
  assign busy    = 1'b0;
  assign w_nop   = ealuc[3];
  assign w_no_wb = 1'b0;
`endif

  assign w_accept = in_valid & ~stall;
  assign w_a      = eshift  ? WIDTH'(eimm[5 +: SH_W]) : ea;
  assign w_b      = ealuimm ? eimm : eb;

  // Single-cycle ALU result (and HI/LO moves when the MDU is present).
  always_comb begin
    w_res = '0;
    case (ealuc)
      OP_ADD:  w_res = w_a + w_b;
      OP_SUB:  w_res = w_a - w_b;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_SLL:  w_res = w_b << w_a[SH_W-1:0];
      OP_SRL:  w_res = w_b >> w_a[SH_W-1:0];
      OP_SRA:  w_res = WIDTH'($signed(w_b) >>> w_a[SH_W-1:0]);
`ifdef EXE_MDU_EN
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
`endif
      default: w_res = '0;
    endcase
  end

  // EX/MEM register: load accepted instructions, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      mm2reg  <= 1'b0;
      mwmem   <= 1'b0;
      mwreg   <= 1'b0;
      mrn     <= '0;
      malu    <= '0;
      mb      <= '0;
      mz      <= 1'b0;
    end else if (w_accept && !w_nop) begin
      m_valid <= 1'b1;
      mm2reg  <= em2reg;
      mwmem   <= ewmem & ~w_no_wb;
      mwreg   <= ewreg & ~w_no_wb;
      mrn     <= ern;
      malu    <= w_res;
      mb      <= eb;
      mz      <= (w_res == '0);
    end else begin
      m_valid <= 1'b0;
      mm2reg  <= 1'b0;
      mwmem   <= 1'b0;
      mwreg   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed self-checking bench for exe_stage_pipe (WIDTH=32).
// MDU sequences are exercised only when EXE_MDU_EN is defined; otherwise
// codes 8-11 are checked as bubbles.
module tb_exe_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift;
  logic [31:0] ea, eb, eimm;
  logic        em2reg, ewmem, ewreg;
  logic [4:0]  ern;
  logic        stall, busy, m_valid, mm2reg, mwmem, mwreg, mz;
  logic [4:0]  mrn;
  logic [31:0] malu, mb;

  int n_checks = 0;
  int n_fail   = 0;

  exe_stage_pipe #(.WIDTH(32), .RN_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ealuc(ealuc),
    .ealuimm(ealuimm), .eshift(eshift), .ea(ea), .eb(eb), .eimm(eimm),
    .em2reg(em2reg), .ewmem(ewmem), .ewreg(ewreg), .ern(ern),
    .stall(stall), .busy(busy), .m_valid(m_valid), .mm2reg(mm2reg),
    .mwmem(mwmem), .mwreg(mwreg), .mrn(mrn), .malu(malu), .mb(mb), .mz(mz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic aluimm, input logic sh,
                       input logic wreg, input logic [4:0] rn);
    in_valid = 1'b1;
    ealuc    = op;
    ea       = a;
    eb       = b;
    eimm     = imm;
    ealuimm  = aluimm;
    eshift   = sh;
    ewreg    = wreg;
    ewmem    = 1'b0;
    em2reg   = 1'b0;
    ern      = rn;
  endtask

`ifdef EXE_MDU_EN
  // Hold the presented instruction until stall drops; returns stalled cycles.
  task automatic wait_stall(output int n);
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("rst_malu", malu, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_mwreg", {31'd0, mwreg}, 32'd0);
    chk("rst_mrn", {27'd0, mrn}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // ADD 5+7
    drive(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    tick();
    chk("add_malu", malu, 32'd12);
    chk("add_mz", {31'd0, mz}, 32'd0);
    chk("add_mwreg", {31'd0, mwreg}, 32'd1);
    chk("add_mrn", {27'd0, mrn}, 32'd3);
    chk("add_valid", {31'd0, m_valid}, 32'd1);
    chk("add_mb", mb, 32'd7);

    // SUB with immediate giving zero
    drive(4'd1, 32'd9, 32'd100, 32'd9, 1'b1, 1'b0, 1'b1, 5'd4);
    tick();
    chk("sub_malu", malu, 32'd0);
    chk("sub_mz", {31'd0, mz}, 32'd1);

    // SRA by shift amount taken from eimm[9:5]=4
    drive(4'd7, 32'd0, 32'h8000_0000, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    chk("sra_malu", malu, 32'hF800_0000);

    // SLL by zero (ea=32, low five bits clear)
    drive(4'd5, 32'd32, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    chk("sll0_malu", malu, 32'h1234_5678);

    // SRL by 31
    drive(4'd6, 32'd31, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6);
    tick();
    chk("srl31_malu", malu, 32'd1);

    // ADD wraps
    drive(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    em2reg = 1'b1;
    ewmem  = 1'b1;
    tick();
    chk("wrap_malu", malu, 32'd0);
    chk("wrap_mz", {31'd0, mz}, 32'd1);
    chk("wrap_mm2reg", {31'd0, mm2reg}, 32'd1);
    chk("wrap_mwmem", {31'd0, mwmem}, 32'd1);

    // Logic ops
    drive(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8);
    tick();
    chk("and_malu", malu, 32'h0000_F000);
    drive(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8);
    tick();
    chk("or_malu", malu, 32'h0000_FFF0);
    drive(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    tick();
    chk("xor_malu", malu, 32'h0000_0FF0);
    chk("xor_mrn", {27'd0, mrn}, 32'd9);

    // in_valid low: bubble, result held
    drive(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd10);
    in_valid = 1'b0;
    tick();
    chk("inv_valid", {31'd0, m_valid}, 32'd0);
    chk("inv_mwreg", {31'd0, mwreg}, 32'd0);
    chk("inv_hold", malu, 32'h0000_0FF0);

    // NOP code 12: bubble
    drive(4'd12, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11);
    ewmem = 1'b1;
    tick();
    chk("nop_valid", {31'd0, m_valid}, 32'd0);
    chk("nop_mwreg", {31'd0, mwreg}, 32'd0);
    chk("nop_mwmem", {31'd0, mwmem}, 32'd0);
    chk("nop_hold", malu, 32'h0000_0FF0);

`ifdef EXE_MDU_EN
    // MULTU 0xFFFFFFFF * 2
    drive(4'd8, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    tick();
    chk("mul_busy", {31'd0, busy}, 32'd1);
    chk("mul_mwreg", {31'd0, mwreg}, 32'd0);
    // independent ADD flows during busy
    drive(4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 1'b0, 1'b1, 5'd13);
    chk("busy_add_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("busy_add_malu", malu, 32'd42);
    chk("busy_add_valid", {31'd0, m_valid}, 32'd1);
    // MFHI waits for completion
    drive(4'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd14);
    chk("mfhi_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("stall_bubble", {31'd0, m_valid}, 32'd0);
    wait_stall(n);
    chk("mul_stall_cycles", 32'(n + 1), 32'd31);
    tick();
    chk("mfhi_malu", malu, 32'h0000_0001);
    chk("mfhi_valid", {31'd0, m_valid}, 32'd1);
    drive(4'd11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd14);
    tick();
    chk("mflo_malu", malu, 32'hFFFF_FFFE);

    // DIVU 100/7
    drive(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd15);
    tick();
    drive(4'd11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd15);
    wait_stall(n);
    chk("div_stall_cycles", 32'(n), 32'd32);
    tick();
    chk("div_lo", malu, 32'd14);
    drive(4'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd15);
    tick();
    chk("div_hi", malu, 32'd2);

    // DIVU 55/0
    drive(4'd9, 32'd55, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd16);
    tick();
    drive(4'd11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd16);
    wait_stall(n);
    chk("div0_stall_cycles", 32'(n), 32'd32);
    tick();
    chk("div0_lo", malu, 32'hFFFF_FFFF);
    drive(4'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd16);
    tick();
    chk("div0_hi", malu, 32'd55);

    // Reset aborts a DIVU in flight
    drive(4'd9, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd17);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    drive(4'd11, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_malu", malu, 32'd0);
    chk("abort_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("abort_mflo", malu, 32'd0);
    chk("abort_mflo_valid", {31'd0, m_valid}, 32'd1);
    drive(4'd10, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd18);
    tick();
    chk("abort_mfhi", malu, 32'd0);
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
`else
    // Without the MDU, codes 8-11 are bubbles and never stall
    drive(4'd8, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    chk("nomdu_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("nomdu_mul_valid", {31'd0, m_valid}, 32'd0);
    chk("nomdu_busy", {31'd0, busy}, 32'd0);
    drive(4'd10, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    tick();
    chk("nomdu_mfhi_valid", {31'd0, m_valid}, 32'd0);
    chk("nomdu_mfhi_mwreg", {31'd0, mwreg}, 32'd0);
    chk("nomdu_hold", malu, 32'h0000_0FF0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
